bcd_fib_entry: RTL and testbench

Operator front end that sits directly upstream of the BCD Fibonacci stage. It takes four raw, bouncing push-buttons, synchronises and debounces each one, and keeps a two-digit BCD operand (00-99) that is edited by button presses. It drives the downstream stage's bcd1/bcd0 operand inputs and a single-cycle start pulse.

---
 rtl/bcd_fib_entry.sv | 175 +++++++++++++++++
 tb/tb_bcd_fib_entry.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_fib_entry.sv
// Operator front end for the BCD Fibonacci stage: four debounced buttons edit a
// two-digit BCD operand and issue a one-cycle start pulse downstream.

module bcd_fib_debounce #(
    parameter int DB_TICKS = 1_000_000,
    parameter int DB_W     = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic rise
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    localparam logic [DB_W-1:0] LOAD = DB_W'(DB_TICKS - 1);
    localparam logic [DB_W-1:0] LAST = DB_W'(1);

    logic [1:0]      sync;
    logic            level;
    db_state_t       state, state_nx;
    logic [DB_W-1:0] cnt, cnt_nx;
    logic            db, db_nx;
    logic            db_prev;

    assign level = sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            state   <= ZERO;
            cnt     <= '0;
            db      <= 1'b0;
            db_prev <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            state   <= state_nx;
            cnt     <= cnt_nx;
            db      <= db_nx;
            db_prev <= db;
        end
    end

    // The counter is loaded on the first differing sample, so db flips on the
    // DB_TICKS-th consecutive differing sample.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        db_nx    = db;
        unique case (state)
            ZERO: begin
                if (level) begin
                    cnt_nx   = LOAD;
                    state_nx = WAIT1;
                end
            end
            WAIT1: begin
                if (!level) begin
                    state_nx = ZERO;
                end else if (cnt <= LAST) begin
                    cnt_nx   = '0;
                    state_nx = ONE;
                    db_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt - LAST;
                end
            end
            ONE: begin
                if (!level) begin
                    cnt_nx   = LOAD;
                    state_nx = WAIT0;
                end
            end
            WAIT0: begin
                if (level) begin
                    state_nx = ONE;
                end else if (cnt <= LAST) begin
                    cnt_nx   = '0;
                    state_nx = ZERO;
                    db_nx    = 1'b0;
                end else begin
                    cnt_nx = cnt - LAST;
                end
            end
            default: begin
                state_nx = ZERO;
            end
        endcase
    end

    assign rise = db & ~db_prev;
endmodule

module bcd_fib_digit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hold,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit <= 4'd0;
        end else if (!hold) begin
            if (clr) begin
                digit <= 4'd0;
            end else if (inc) begin
                digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end
        end
    end
endmodule

module bcd_fib_entry #(
    parameter int DB_TICKS = 1_000_000,
    parameter int DB_W     = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_inc1,
    input  logic       btn_inc0,
    input  logic       btn_clr,
    input  logic       btn_go,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       start
);
    logic ev_inc1, ev_inc0, ev_clr, ev_go;
    logic pend_inc1, pend_inc0, pend_clr;
    logic do_inc1, do_inc0, do_clr;

    bcd_fib_debounce #(.DB_TICKS(DB_TICKS), .DB_W(DB_W)) u_db_inc1 (
        .clk(clk), .reset_n(reset_n), .btn(btn_inc1), .rise(ev_inc1)
    );
    bcd_fib_debounce #(.DB_TICKS(DB_TICKS), .DB_W(DB_W)) u_db_inc0 (
        .clk(clk), .reset_n(reset_n), .btn(btn_inc0), .rise(ev_inc0)
    );
    bcd_fib_debounce #(.DB_TICKS(DB_TICKS), .DB_W(DB_W)) u_db_clr (
        .clk(clk), .reset_n(reset_n), .btn(btn_clr), .rise(ev_clr)
    );
    bcd_fib_debounce #(.DB_TICKS(DB_TICKS), .DB_W(DB_W)) u_db_go (
        .clk(clk), .reset_n(reset_n), .btn(btn_go), .rise(ev_go)
    );

    // An edit that coincides with a go event is parked for one cycle so the
    // downstream stage samples the pre-edit operand alongside start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start     <= 1'b0;
            pend_inc1 <= 1'b0;
            pend_inc0 <= 1'b0;
            pend_clr  <= 1'b0;
        end else begin
            start     <= ev_go;
            pend_inc1 <= ev_go & ev_inc1;
            pend_inc0 <= ev_go & ev_inc0;
            pend_clr  <= ev_go & ev_clr;
        end
    end

    always_comb begin
        do_inc1 = ev_inc1 | pend_inc1;
        do_inc0 = ev_inc0 | pend_inc0;
        do_clr  = ev_clr  | pend_clr;
    end

    bcd_fib_digit u_tens (
        .clk(clk), .reset_n(reset_n), .hold(ev_go),
        .clr(do_clr), .inc(do_inc1), .digit(bcd1)
    );
    bcd_fib_digit u_units (
        .clk(clk), .reset_n(reset_n), .hold(ev_go),
        .clr(do_clr), .inc(do_inc0), .digit(bcd0)
    );
endmodule

// File: tb/tb_bcd_fib_entry.sv
// Self-checking bench for bcd_fib_entry: behavioural model plus directed and random buttons.

module tb_bcd_fib_entry;
    localparam int DB_TICKS = 4;
    localparam int DB_W     = 20;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       btn_inc1 = 1'b0;
    logic       btn_inc0 = 1'b0;
    logic       btn_clr  = 1'b0;
    logic       btn_go   = 1'b0;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic       start;

    int checks      = 0;
    int failures    = 0;
    int pulse_count = 0;

    // Model: bit order inc1, inc0, clr, go
    bit [3:0] m_s1   = '0;
    bit [3:0] m_s2   = '0;
    bit [3:0] m_db   = '0;
    bit [3:0] m_prev = '0;
    bit [2:0] m_pend = '0;
    int       m_run [4];
    int       m_bcd1 = 0;
    int       m_bcd0 = 0;
    bit       m_start = 1'b0;

    bcd_fib_entry #(.DB_TICKS(DB_TICKS), .DB_W(DB_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_inc1(btn_inc1), .btn_inc0(btn_inc0), .btn_clr(btn_clr), .btn_go(btn_go),
        .bcd1(bcd1), .bcd0(bcd0), .start(start)
    );

    always #5 clk = ~clk;

    // A button's clean level follows its synchronised level once that level has
    // differed from it for DB_TICKS samples in a row; a clean rise is one event.
    always @(posedge clk or negedge reset_n) begin
        bit [3:0] ev;
        bit [2:0] eff;
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0; m_pend = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_bcd1 = 0; m_bcd0 = 0; m_start = 1'b0;
        end else begin
            ev = m_db & ~m_prev;
            m_prev = m_db;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB_TICKS) begin
                        m_db[i]  = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {btn_go, btn_clr, btn_inc0, btn_inc1};
            m_start = ev[3];
            if (ev[3]) begin
                m_pend = ev[2:0];
            end else begin
                eff = ev[2:0] | m_pend;
                m_pend = '0;
                if (eff[2]) begin
                    m_bcd1 = 0;
                    m_bcd0 = 0;
                end else begin
                    if (eff[0]) m_bcd1 = (m_bcd1 + 1) % 10;
                    if (eff[1]) m_bcd0 = (m_bcd0 + 1) % 10;
                end
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check_output("reset_bcd1", int'(bcd1), 0);
                check_output("reset_bcd0", int'(bcd0), 0);
                check_output("reset_start", int'(start), 0);
            end else begin
                check_output("bcd1", int'(bcd1), m_bcd1);
                check_output("bcd0", int'(bcd0), m_bcd0);
                check_output("start", int'(start), int'(m_start));
                if (start) pulse_count++;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_buttons(input logic [3:0] b);
        {btn_go, btn_clr, btn_inc0, btn_inc1} = b;
    endtask

    task automatic apply_stimulus(input logic [3:0] b);
        set_buttons(b);
        tick(DB_TICKS + 2);
        set_buttons(4'b0000);
        tick(2 * DB_TICKS + 4);
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (start) seen = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        int base;
        fork
            compare_loop();
        join_none

        // Reset held while the buttons thrash
        repeat (6) begin
            @(posedge clk);
            #1;
            set_buttons(4'($urandom_range(0, 15)));
        end
        set_buttons(4'b0000);
        tick(1);
        reset_n = 1'b1;
        base = pulse_count;
        tick(20);
        check_output("post_reset_pulses", pulse_count - base, 0);
        check_output("post_reset_bcd0", int'(bcd0), 0);

        // Glitches shorter than DB_TICKS are ignored
        set_buttons(4'b0010); tick(3);
        set_buttons(4'b0000); tick(1);
        set_buttons(4'b0010); tick(3);
        set_buttons(4'b0000); tick(10);
        check_output("glitch_bcd0", int'(bcd0), 0);

        // Latency DB_TICKS+3 edges from the first sampling edge
        set_buttons(4'b0010);
        tick(DB_TICKS + 2);
        check_output("latency_before", int'(bcd0), 0);
        tick(1);
        check_output("latency_at", int'(bcd0), 1);
        tick(3);
        check_output("held_no_repeat", int'(bcd0), 1);
        set_buttons(4'b0000);
        tick(12);

        // Units wrap without carry, tens wrap
        apply_stimulus(4'b0100);
        for (int k = 1; k <= 10; k++) begin
            apply_stimulus(4'b0010);
            check_output("wrap_bcd0", int'(bcd0), k % 10);
        end
        check_output("wrap_bcd1", int'(bcd1), 0);
        for (int k = 0; k < 12; k++) apply_stimulus(4'b0001);
        check_output("tens_12", int'(bcd1), 2);

        // Clear wins over a same-cycle increment
        apply_stimulus(4'b0100);
        for (int k = 0; k < 3; k++) apply_stimulus(4'b0011);
        for (int k = 0; k < 4; k++) apply_stimulus(4'b0010);
        check_output("setup_bcd1", int'(bcd1), 3);
        check_output("setup_bcd0", int'(bcd0), 7);
        apply_stimulus(4'b0101);
        check_output("clr_prio_bcd1", int'(bcd1), 0);
        check_output("clr_prio_bcd0", int'(bcd0), 0);

        // Start pulse with operand 2,5; long hold gives one pulse
        for (int k = 0; k < 2; k++) apply_stimulus(4'b0011);
        for (int k = 0; k < 3; k++) apply_stimulus(4'b0010);
        base = pulse_count;
        set_buttons(4'b1000);
        wait_start(seen);
        check_output("go_seen", int'(seen), 1);
        check_output("go_bcd1", int'(bcd1), 2);
        check_output("go_bcd0", int'(bcd0), 5);
        repeat (43) @(negedge clk);
        set_buttons(4'b0000);
        tick(12);
        check_output("go_pulses", pulse_count - base, 1);

        // Same-cycle go and inc0 at 0,9: edit shows one cycle after the pulse
        apply_stimulus(4'b0100);
        for (int k = 0; k < 9; k++) apply_stimulus(4'b0010);
        set_buttons(4'b1010);
        wait_start(seen);
        check_output("go_inc_seen", int'(seen), 1);
        check_output("go_inc_during", int'(bcd0), 9);
        @(negedge clk);
        check_output("go_inc_after", int'(bcd0), 0);
        check_output("go_inc_bcd1", int'(bcd1), 0);
        set_buttons(4'b0000);
        tick(12);

        // Reset during the go debounce aborts it
        base = pulse_count;
        set_buttons(4'b1000);
        tick(4);
        reset_n = 1'b0;
        set_buttons(4'b0000);
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check_output("abort_pulses", pulse_count - base, 0);

        // Random button activity with occasional resets
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                set_buttons(4'b0000);
                tick(2);
                reset_n = 1'b1;
            end
            set_buttons(4'($urandom_range(0, 15)));
            tick($urandom_range(1, 10));
        end
        set_buttons(4'b0000);
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
